// File: rtl/ov7670_reg_init.sv
`default_nettype none
// ============================================================================
// Module   : ov7670_reg_init
// Brief    : Boot-time OV7670 register loader; walks a (reg, value) ROM and
//            issues one SCCB write per entry through i2c_master's command and
//            write-data streams. Define OV7670_INIT_RETRY_EN to retry NACKed
//            entries up to MAX_RETRY times before flagging an error.
// Revision : 1.0 - initial release
// ============================================================================
module ov7670_reg_init #(
    parameter logic [6:0]  DEVICE_ADDR   = 7'h21,
    parameter int unsigned SETTLE_CYCLES = 100000,
    parameter int unsigned BUSY_WAIT_MAX = 15,
    parameter int unsigned MAX_RETRY     = 3,
    parameter bit          AUTO_START    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [6:0] cmd_address,
    output logic       cmd_start,
    output logic       cmd_read,
    output logic       cmd_write,
    output logic       cmd_write_multiple,
    output logic       cmd_stop,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] data_tdata,
    output logic       data_tvalid,
    input  logic       data_tready,
    output logic       data_tlast,
    input  logic       i2c_busy,
    input  logic       i2c_missed_ack,
    output logic       running,
    output logic       done,
    output logic       error,
    output logic [7:0] index,
    output logic [7:0] nack_count
);

    localparam logic [3:0] c_ST_IDLE    = 4'd0;
    localparam logic [3:0] c_ST_FETCH   = 4'd1;
    localparam logic [3:0] c_ST_DECODE  = 4'd2;
    localparam logic [3:0] c_ST_CMD     = 4'd3;
    localparam logic [3:0] c_ST_DATA0   = 4'd4;
    localparam logic [3:0] c_ST_DATA1   = 4'd5;
    localparam logic [3:0] c_ST_WAIT_HI = 4'd6;
    localparam logic [3:0] c_ST_WAIT_LO = 4'd7;
    localparam logic [3:0] c_ST_CHECK   = 4'd8;
    localparam logic [3:0] c_ST_DELAY   = 4'd9;
    localparam logic [3:0] c_ST_NEXT    = 4'd10;
    localparam logic [3:0] c_ST_FINISH  = 4'd11;

    localparam logic [15:0] c_ENTRY_END   = 16'hFFFF;
    localparam logic [15:0] c_ENTRY_DELAY = 16'hFFF0;

`ifdef OV7670_INIT_RETRY_EN
    localparam bit c_RETRY_EN = 1'b1;
`else
    localparam bit c_RETRY_EN = 1'b0;
`endif

    logic [3:0]  r_state;
    logic [7:0]  r_index;
    logic [7:0]  r_nack_count;
    logic        r_done;
    logic        r_error;
    logic        r_start_pending;
    logic        r_nack_seen;
    logic [15:0] r_entry;
    logic [31:0] r_wait_cnt;
    logic [31:0] r_delay_cnt;
    logic [31:0] r_retry_cnt;
    logic        w_go;
    logic        w_in_xfer;

    // Register table: {reg, value}; entry 0 soft-resets the sensor, entry 1 waits for it.
    function automatic logic [15:0] f_rom(input logic [7:0] addr);
        case (addr)
            8'd0:    f_rom = 16'h1280;
            8'd1:    f_rom = c_ENTRY_DELAY;
            8'd2:    f_rom = 16'h1204;
            8'd3:    f_rom = 16'h1100;
            8'd4:    f_rom = 16'h0C00;
            8'd5:    f_rom = 16'h3E00;
            8'd6:    f_rom = 16'h4010;
            8'd7:    f_rom = 16'h3A04;
            8'd8:    f_rom = 16'h8C00;
            8'd9:    f_rom = 16'h1438;
            8'd10:   f_rom = 16'h4FB3;
            8'd11:   f_rom = 16'h50B3;
            8'd12:   f_rom = 16'h5100;
            8'd13:   f_rom = 16'h523D;
            8'd14:   f_rom = 16'h53A7;
            8'd15:   f_rom = 16'h54E4;
            8'd16:   f_rom = 16'h589E;
            8'd17:   f_rom = 16'h3DC0;
            default: f_rom = c_ENTRY_END;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        r_entry <= f_rom(r_index);
    end

    // A pending start survives until i2c_master is idle, so a reset mid-write never overlaps it.
    assign w_go      = (start || r_start_pending) && !i2c_busy;
    assign w_in_xfer = (r_state >= c_ST_CMD) && (r_state <= c_ST_WAIT_LO);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_ST_IDLE;
            r_index         <= 8'd0;
            r_nack_count    <= 8'd0;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
            r_start_pending <= AUTO_START;
            r_nack_seen     <= 1'b0;
            r_wait_cnt      <= 32'd0;
            r_delay_cnt     <= 32'd0;
            r_retry_cnt     <= 32'd0;
        end else begin
            if (w_in_xfer && i2c_missed_ack) begin
                r_nack_seen <= 1'b1;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_go) begin
                        r_state         <= c_ST_FETCH;
                        r_index         <= 8'd0;
                        r_nack_count    <= 8'd0;
                        r_done          <= 1'b0;
                        r_error         <= 1'b0;
                        r_start_pending <= 1'b0;
                    end else if (start) begin
                        r_start_pending <= 1'b1;
                    end
                end
                c_ST_FETCH: begin
                    r_nack_seen <= 1'b0;
                    r_retry_cnt <= 32'd0;
                    r_state     <= c_ST_DECODE;
                end
                c_ST_DECODE: begin
                    if (r_entry == c_ENTRY_END) begin
                        r_state <= c_ST_FINISH;
                    end else if (r_entry == c_ENTRY_DELAY) begin
                        r_delay_cnt <= 32'd0;
                        r_state     <= c_ST_DELAY;
                    end else begin
                        r_state <= c_ST_CMD;
                    end
                end
                c_ST_CMD: begin
                    if (cmd_ready) r_state <= c_ST_DATA0;
                end
                c_ST_DATA0: begin
                    if (data_tready) r_state <= c_ST_DATA1;
                end
                c_ST_DATA1: begin
                    if (data_tready) begin
                        r_wait_cnt <= 32'd0;
                        r_state    <= c_ST_WAIT_HI;
                    end
                end
                c_ST_WAIT_HI: begin
                    if (i2c_busy || (r_wait_cnt == BUSY_WAIT_MAX - 1)) begin
                        r_state <= c_ST_WAIT_LO;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 32'd1;
                    end
                end
                c_ST_WAIT_LO: begin
                    if (!i2c_busy) r_state <= c_ST_CHECK;
                end
                c_ST_CHECK: begin
                    if (r_nack_seen) begin
                        if (r_nack_count != 8'hFF) r_nack_count <= r_nack_count + 8'd1;
                        if (c_RETRY_EN && (r_retry_cnt < MAX_RETRY)) begin
                            r_retry_cnt <= r_retry_cnt + 32'd1;
                            r_nack_seen <= 1'b0;
                            r_state     <= c_ST_CMD;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= c_ST_NEXT;
                        end
                    end else begin
                        r_state <= c_ST_NEXT;
                    end
                end
                c_ST_DELAY: begin
                    // The index advance is folded into the last delay cycle so the
                    // delay entry costs SETTLE_CYCLES+2 from FETCH to FETCH.
                    if (r_delay_cnt == SETTLE_CYCLES - 1) begin
                        if (r_index == 8'hFF) begin
                            r_state <= c_ST_FINISH;
                        end else begin
                            r_index <= r_index + 8'd1;
                            r_state <= c_ST_FETCH;
                        end
                    end else begin
                        r_delay_cnt <= r_delay_cnt + 32'd1;
                    end
                end
                c_ST_NEXT: begin
                    if (r_index == 8'hFF) begin
                        r_state <= c_ST_FINISH;
                    end else begin
                        r_index <= r_index + 8'd1;
                        r_state <= c_ST_FETCH;
                    end
                end
                c_ST_FINISH: begin
                    r_done  <= 1'b1;
                    r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign cmd_address        = DEVICE_ADDR;
    assign cmd_valid          = (r_state == c_ST_CMD);
    assign cmd_start          = cmd_valid;
    assign cmd_write_multiple = cmd_valid;
    assign cmd_stop           = cmd_valid;
    assign cmd_read           = 1'b0;
    assign cmd_write          = 1'b0;

    assign data_tvalid = (r_state == c_ST_DATA0) || (r_state == c_ST_DATA1);
    assign data_tlast  = (r_state == c_ST_DATA1);

    always_comb begin
        data_tdata = 8'd0;
        if (r_state == c_ST_DATA0) data_tdata = r_entry[15:8];
        else if (r_state == c_ST_DATA1) data_tdata = r_entry[7:0];
    end

    assign running    = (r_state != c_ST_IDLE);
    assign done       = r_done;
    assign error      = r_error;
    assign index      = r_index;
    assign nack_count = r_nack_count;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_reg_init.sv
`default_nettype none
// tb_ov7670_reg_init: randomized SCCB responder, table-level reference model
// and a write scoreboard checked by an independent monitor.
module tb_ov7670_reg_init;

    localparam int unsigned c_SETTLE    = 50;
    localparam int unsigned c_BUSY_WAIT = 15;
    localparam int unsigned c_MAX_RETRY = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       data_tready = 1'b0;
    logic       i2c_busy = 1'b0;
    logic       i2c_missed_ack = 1'b0;
    logic [6:0] cmd_address;
    logic       cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop, cmd_valid;
    logic [7:0] data_tdata;
    logic       data_tvalid, data_tlast;
    logic       running, done, error;
    logic [7:0] index, nack_count;

    always #5 clk = ~clk;

    ov7670_reg_init #(
        .DEVICE_ADDR   (7'h21),
        .SETTLE_CYCLES (c_SETTLE),
        .BUSY_WAIT_MAX (c_BUSY_WAIT),
        .MAX_RETRY     (c_MAX_RETRY),
        .AUTO_START    (1'b1)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .cmd_address        (cmd_address),
        .cmd_start          (cmd_start),
        .cmd_read           (cmd_read),
        .cmd_write          (cmd_write),
        .cmd_write_multiple (cmd_write_multiple),
        .cmd_stop           (cmd_stop),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .data_tdata         (data_tdata),
        .data_tvalid        (data_tvalid),
        .data_tready        (data_tready),
        .data_tlast         (data_tlast),
        .i2c_busy           (i2c_busy),
        .i2c_missed_ack     (i2c_missed_ack),
        .running            (running),
        .done               (done),
        .error              (error),
        .index              (index),
        .nack_count         (nack_count)
    );

    typedef struct {
        int          idx;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_nack, exp_err, exp_end;

    int   nack_entry = -1, nack_left = 0, stall_entry = -1, block_entry = -1;
    bit   stall_used = 1'b0;
    logic force_busy = 1'b0;
    int   m_st = 0, m_cnt = 0;
    bit   m_busy = 1'b0, m_nack = 1'b0;

    int         cycle = 0, t_idx1 = -1, t_idx2 = -1;
    logic [7:0] beat0, last_idx, pv_tdata;
    bit         have0 = 1'b0, pv_cmd = 1'b0, pv_data = 1'b0, pv_last = 1'b0;

    function automatic logic [15:0] table_entry(input int i);
        case (i)
            0:  table_entry = 16'h1280;  1:  table_entry = 16'hFFF0;
            2:  table_entry = 16'h1204;  3:  table_entry = 16'h1100;
            4:  table_entry = 16'h0C00;  5:  table_entry = 16'h3E00;
            6:  table_entry = 16'h4010;  7:  table_entry = 16'h3A04;
            8:  table_entry = 16'h8C00;  9:  table_entry = 16'h1438;
            10: table_entry = 16'h4FB3;  11: table_entry = 16'h50B3;
            12: table_entry = 16'h5100;  13: table_entry = 16'h523D;
            14: table_entry = 16'h53A7;  15: table_entry = 16'h54E4;
            16: table_entry = 16'h589E;  17: table_entry = 16'h3DC0;
            default: table_entry = 16'hFFFF;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: walk the table, expand each write into the attempts the NACK policy implies.
    task automatic build_expect(input int ne, input int nt);
        exp_t e;
        int   fails, sends, nacks;
        exp_q.delete();
        exp_nack = 0;
        exp_err  = 0;
        exp_end  = 255;
        for (int i = 0; i < 256; i++) begin
            if (table_entry(i) == 16'hFFFF) begin
                exp_end = i;
                break;
            end
            if (table_entry(i) != 16'hFFF0) begin
                fails = (i == ne) ? nt : 0;
`ifdef OV7670_INIT_RETRY_EN
                sends = (fails > int'(c_MAX_RETRY)) ? int'(c_MAX_RETRY) + 1 : fails + 1;
                nacks = (fails > int'(c_MAX_RETRY)) ? int'(c_MAX_RETRY) + 1 : fails;
                if (fails > int'(c_MAX_RETRY)) exp_err = 1;
`else
                sends = 1;
                nacks = (fails > 0) ? 1 : 0;
                if (fails > 0) exp_err = 1;
`endif
                exp_nack = (exp_nack + nacks > 255) ? 255 : exp_nack + nacks;
                for (int s = 0; s < sends; s++) begin
                    e.idx  = i;
                    e.data = table_entry(i);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // SCCB responder standing in for i2c_master.
    initial begin : responder
        forever begin
            @(posedge clk);
            #1;
            cmd_ready      = 1'b0;
            data_tready    = 1'b0;
            i2c_missed_ack = 1'b0;
            if (rst) begin
                m_st   = 0;
                m_busy = 1'b0;
                m_nack = 1'b0;
            end else begin
                if (m_st == 0 && cmd_valid) begin
                    if (int'(index) == stall_entry && !stall_used) begin
                        m_cnt      = 20;
                        stall_used = 1'b1;
                    end else begin
                        m_cnt = int'($urandom_range(0, 2));
                    end
                    m_st = 1;
                end
                if (m_st == 1) begin
                    if (m_cnt == 0) begin
                        cmd_ready = 1'b1;
                        m_st      = 2;
                        m_cnt     = int'($urandom_range(0, 2));
                    end else m_cnt--;
                end else if (m_st == 2) begin
                    if (data_tvalid && !(data_tlast && int'(index) == block_entry)) begin
                        if (m_cnt == 0) begin
                            data_tready = 1'b1;
                            if (data_tlast) begin
                                m_st  = 3;
                                m_cnt = int'($urandom_range(0, 3));
                            end else m_cnt = int'($urandom_range(0, 2));
                        end else m_cnt--;
                    end
                end else if (m_st == 3) begin
                    if (m_cnt == 0) begin
                        m_busy = 1'b1;
                        m_nack = (int'(index) == nack_entry) && (nack_left > 0);
                        if (m_nack) nack_left--;
                        if (m_nack && $urandom_range(0, 1) == 1) begin
                            i2c_missed_ack = 1'b1;
                            m_nack         = 1'b0;
                        end
                        m_cnt = int'($urandom_range(1, 6));
                        m_st  = 4;
                    end else m_cnt--;
                end else if (m_st == 4) begin
                    if (m_nack && m_cnt == 1) begin
                        i2c_missed_ack = 1'b1;
                        m_nack         = 1'b0;
                    end
                    if (m_cnt == 0) begin
                        m_busy = 1'b0;
                        m_st   = 0;
                    end else m_cnt--;
                end
            end
            i2c_busy = m_busy | force_busy;
        end
    end

    // Monitor: protocol holds, command fields and completed writes against the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cycle++;
            if (rst) begin
                have0    = 1'b0;
                pv_cmd   = 1'b0;
                pv_data  = 1'b0;
                last_idx = 8'd0;
            end else begin
                if (pv_cmd) chk("cmd_valid_hold", 32'(cmd_valid), 32'd1);
                if (pv_data) chk("data_hold", 32'({data_tvalid, data_tlast, data_tdata}),
                                 32'({1'b1, pv_last, pv_tdata}));
                if (cmd_valid && cmd_ready)
                    chk("cmd_fields", 32'({cmd_address, cmd_start, cmd_write_multiple, cmd_stop,
                                           cmd_read, cmd_write}), 32'({7'h21, 3'b111, 2'b00}));
                if (data_tvalid && data_tready) begin
                    if (!data_tlast) begin
                        beat0 = data_tdata;
                        have0 = 1'b1;
                    end else begin
                        if (exp_q.size() > 0) e = exp_q.pop_front();
                        else begin
                            e.idx  = -1;
                            e.data = 16'h0000;
                        end
                        chk("write_index", 32'(index), 32'(e.idx));
                        chk("write_pair", 32'({beat0, data_tdata}), 32'(e.data));
                        chk("write_beat0_seen", 32'(have0), 32'd1);
                        have0 = 1'b0;
                    end
                end
                pv_cmd   = cmd_valid && !cmd_ready;
                pv_data  = data_tvalid && !data_tready;
                pv_last  = data_tlast;
                pv_tdata = data_tdata;
                if (index != last_idx) begin
                    if (index == 8'd1 && t_idx1 < 0) t_idx1 = cycle;
                    if (index == 8'd2 && t_idx2 < 0) t_idx2 = cycle;
                    last_idx = index;
                end
            end
        end
    end

    task automatic chk_reset_values();
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_data_tvalid", 32'(data_tvalid), 32'd0);
        chk("rst_data_tlast", 32'(data_tlast), 32'd0);
        chk("rst_data_tdata", 32'(data_tdata), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_index", 32'(index), 32'd0);
        chk("rst_nack_count", 32'(nack_count), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst    = 1'b1;
        t_idx1 = -1;
        t_idx2 = -1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_values();
    endtask

    task automatic finish_checks(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", 32'(done), 32'd1);
        chk("final_error", 32'(error), 32'(exp_err));
        chk("final_nack_count", 32'(nack_count), 32'(exp_nack));
        chk("final_index", 32'(index), 32'(exp_end));
        chk("final_running", 32'(running), 32'd0);
        chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int hi;
        int n;
        // Clean run with a 20-cycle command stall on entry 4.
        build_expect(-1, 0);
        stall_entry = 4;
        stall_used  = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();
        finish_checks(5000);
        chk("settle_gap", 32'(t_idx2 - t_idx1), 32'(c_SETTLE + 2));
        stall_entry = -1;

        // Single NACK on entry 3.
        build_expect(3, 1);
        nack_entry = 3;
        nack_left  = 1;
        do_reset();
        finish_checks(5000);

        // Persistent NACK on entry 3, with a start pulse while running.
        build_expect(3, 1000);
        nack_left = 1000;
        do_reset();
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("running_before_stray_start", 32'(running), 32'd1);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        finish_checks(5000);
        nack_entry = -1;
        nack_left  = 0;

        // Explicit start after done: latency and cleared status.
        build_expect(-1, 0);
        @(posedge clk); #1;
        start = 1'b1;
        @(negedge clk);
        chk("start_cycle_running", 32'(running), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("start_n1_running", 32'(running), 32'd1);
        chk("start_n1_done_clear", 32'(done), 32'd0);
        chk("start_n1_error_clear", 32'(error), 32'd0);
        @(negedge clk);
        chk("start_n2_cmd_valid", 32'(cmd_valid), 32'd0);
        @(negedge clk);
        chk("start_n3_cmd_valid", 32'(cmd_valid), 32'd1);
        finish_checks(5000);

        // Reset in DATA1 while i2c_master is busy; restart waits for idle.
        build_expect(-1, 0);
        block_entry = 3;
        do_reset();
        n = 0;
        while (!(data_tvalid && data_tlast && index == 8'd3) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_data1", 32'(data_tvalid && data_tlast), 32'd1);
        @(posedge clk); #1;
        force_busy = 1'b1;
        rst        = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_values();
        build_expect(-1, 0);
        block_entry = -1;
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (running) hi++;
        end
        chk("held_while_busy", 32'(hi), 32'd0);
        @(posedge clk); #1;
        force_busy = 1'b0;
        repeat (4) @(negedge clk);
        chk("restart_after_busy", 32'(running), 32'd1);
        finish_checks(5000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
